load_store_unit: RTL

- RAM-side counterpart of the processor's 16-entry dual-read register file.
- Accepts one load or store command at a time from the sequencer.
- Load (opcode[15:8]=0x92): fetches a word from data RAM and writes it into a register.
- Store (opcode[15:8]=0x91): reads a register and writes it to data RAM.
- Drives the register file's opcode/addr_3/write_data/write_enable inputs and a simple req/ack RAM port.

---
 rtl/load_store_unit_pkg.sv | 22 ++
 rtl/lsu_timeout_counter.sv | 42 ++++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: default word width, the opcode
// values it decodes and the controller state encoding.
package load_store_unit_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  // Operation is selected by opcode[15:8].
  localparam logic [7:0]  LOAD_OP    = 8'h92;
  localparam logic [7:0]  STORE_OP   = 8'h91;
  localparam logic [15:0] NOP_OPCODE = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StLdReq,
    StLdWb,
    StStRd,
    StStReq,
    StStDone,
    StErr
  } lsu_state_e;

endpackage

// File: rtl/lsu_timeout_counter.sv
// Request watchdog for the load/store unit (only instantiated when LSU_TIMEOUT_EN
// is defined).
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : forces the count to zero (held while no request is outstanding)
//   enable     : counts one request cycle
//   expired    : high during the Limit-th consecutive enabled cycle
module lsu_timeout_counter #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed request cycles, so Limit-1 marks the final allowed one.
  assign expired = enable && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: moves one word at a time between the register file and data RAM.
// Loads (opcode[15:8]=0x92) read RAM and write a register; stores (0x91) read a
// register and write RAM; any other opcode completes immediately with error.
// Optional feature: define LSU_TIMEOUT_EN to abort a RAM request after
// TIMEOUT_CYCLES cycles without ram_ack (completes with error).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake; cmd_opcode, cmd_reg, cmd_ram_addr
//   done/error                 : one-cycle completion pulse, error qualifies done
//   rf_opcode/rf_addr_3        : opcode and register index presented to the register file
//   rf_write_data/_enable      : load write-back; rf_read_data_reg : store source data
//   ram_req/ram_we/ram_addr/ram_wdata, ram_ack/ram_rdata : req/ack RAM port
module load_store_unit #(
  parameter int unsigned DATA_WIDTH     = load_store_unit_pkg::DATA_WIDTH,
  parameter int unsigned RAM_ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [15:0]               cmd_opcode,
  input  logic [3:0]                cmd_reg,
  input  logic [RAM_ADDR_WIDTH-1:0] cmd_ram_addr,
  output logic                      done,
  output logic                      error,
  output logic [15:0]               rf_opcode,
  output logic [3:0]                rf_addr_3,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      rf_write_enable,
  input  logic [DATA_WIDTH-1:0]     rf_read_data_reg,
  output logic                      ram_req,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic                      ram_ack,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

  import load_store_unit_pkg::*;

  lsu_state_e                state_q, state_d;
  logic [15:0]               opcode_q;
  logic [3:0]                reg_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      accept;
  logic                      timeout_expired;

  assign accept = cmd_valid && cmd_ready;

`ifdef LSU_TIMEOUT_EN
  logic timeout_clear;

  // Clearing whenever no request is outstanding restarts the count on every entry.
  assign timeout_clear = !((state_q == StLdReq) || (state_q == StStReq));

  lsu_timeout_counter #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (timeout_clear),
    .enable  (ram_req),
    .expired (timeout_expired)
  );
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_expired       = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    cmd_ready       = 1'b0;
    done            = 1'b0;
    error           = 1'b0;
    rf_opcode       = NOP_OPCODE;
    rf_addr_3       = '0;
    rf_write_enable = 1'b0;
    ram_req         = 1'b0;
    ram_we          = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_opcode[15:8] == LOAD_OP) begin
            state_d = StLdReq;
          end else if (cmd_opcode[15:8] == STORE_OP) begin
            state_d = StStRd;
          end else begin
            state_d = StErr;
          end
        end
      end
      StLdReq: begin
        ram_req = 1'b1;
        // An ack in the final counted cycle takes priority over the timeout.
        if (ram_ack) begin
          state_d = StLdWb;
        end else if (timeout_expired) begin
          state_d = StErr;
        end
      end
      StLdWb: begin
        rf_opcode       = opcode_q;
        rf_addr_3       = reg_q;
        rf_write_enable = 1'b1;
        done            = 1'b1;
        state_d         = StIdle;
      end
      StStRd: begin
        rf_opcode = opcode_q;
        rf_addr_3 = reg_q;
        state_d   = StStReq;
      end
      StStReq: begin
        ram_req = 1'b1;
        ram_we  = 1'b1;
        if (ram_ack) begin
          state_d = StStDone;
        end else if (timeout_expired) begin
          state_d = StErr;
        end
      end
      StStDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        done    = 1'b1;
        error   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      opcode_q <= NOP_OPCODE;
      reg_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opcode_q <= cmd_opcode;
        reg_q    <= cmd_reg;
        addr_q   <= cmd_ram_addr;
      end
      if ((state_q == StLdReq) && ram_ack) begin
        rdata_q <= ram_rdata;
      end
      // Register file read is combinational, so the data is valid in StStRd itself.
      if (state_q == StStRd) begin
        wdata_q <= rf_read_data_reg;
      end
    end
  end

  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign rf_write_data = rdata_q;

endmodule
